// File: rtl/uc_fechadura_pkg.sv
// Shared definitions for the lock control unit: state codes and keypad digit width.
// State codes are visible on the debug port, so their values are fixed.
package uc_fechadura_pkg;

  localparam int DIG_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RECEBE    = 4'd1,
    ST_COMPARA   = 4'd2,
    ST_ABERTO    = 4'd3,
    ST_ERRO      = 4'd4,
    ST_EXPIROU   = 4'd5,
    ST_BLOQUEADO = 4'd6
  } estado_t;

endpackage

// File: rtl/temporizador_uc.sv
// Modulo-limit counter shared by every timed state; o_fim is combinational at limit-1.
// Clear has priority over enable; wraps to zero when it reaches the terminal count.
module temporizador_uc #(
  parameter int N_TMR = 4
) (
  input  logic             clock,
  input  logic             zera_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [N_TMR:0]   i_limite,
  output logic             o_fim
);

  logic [N_TMR-1:0] r_cnt;
  logic [N_TMR:0]   w_term;

  assign w_term = i_limite - (N_TMR+1)'(1);
  assign o_fim  = ({1'b0, r_cnt} == w_term);

  always_ff @(posedge clock) begin
    if (!zera_n)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= o_fim ? '0 : r_cnt + N_TMR'(1);
  end

endmodule

// File: rtl/uc_fechadura.sv
// Password-entry control unit: per-digit check, attempt counting, shared timer; result 2 cycles after last digit.
// No backpressure: strobes outside IDLE/RECEBE are dropped. Lockout built only with UC_FECHADURA_BLOQUEIO_EN.
module uc_fechadura
  import uc_fechadura_pkg::*;
#(
  parameter int DIGITOS      = 4,
  parameter int N_POS        = 2,
  parameter int N_TMR        = 4,
  parameter int TIMEOUT      = 8,
  parameter int TEMPO_ABERTO = 4,
  parameter int BLOQUEIO     = 6,
  parameter int MAX_ERROS    = 3
) (
  input  logic                     clock,
  input  logic                     zera_n,
  input  logic                     digito_valido,
  input  logic [DIG_W-1:0]         digito,
  input  logic [DIG_W*DIGITOS-1:0] senha,
  output logic                     aberto,
  output logic                     erro,
  output logic                     expirou,
  output logic                     bloqueado,
  output logic [N_POS-1:0]         posicao,
  output logic [3:0]               tentativas,
  output logic [3:0]               estado
);

  localparam logic [N_POS-1:0] ULTIMA = N_POS'(DIGITOS-1);

  estado_t          r_estado, w_prox;
  logic [N_POS-1:0] r_pos, w_pos_prox;
  logic             r_difere, w_difere_prox;
  logic             w_aceita, w_fim, w_tmr_en, w_tmr_clr;
  logic             w_sucesso, w_falha, w_fim_bloq;
  logic [N_TMR:0]   w_limite;
  logic [DIG_W-1:0] w_dig_esp;

  always_comb begin
    w_dig_esp = '0;
    for (int i = 0; i < DIGITOS; i++)
      if (r_pos == N_POS'(i))
        w_dig_esp = senha[DIG_W*i +: DIG_W];
  end

`ifdef UC_FECHADURA_BLOQUEIO_EN
  logic [3:0] r_tent, w_tent_inc;

  assign w_tent_inc = (r_tent == 4'hF) ? r_tent : r_tent + 4'd1;

  always_ff @(posedge clock) begin
    if (!zera_n)
      r_tent <= '0;
    else if (w_sucesso || w_fim_bloq)
      r_tent <= '0;
    else if (w_falha)
      r_tent <= w_tent_inc;
  end

  assign tentativas = r_tent;
  assign bloqueado  = (r_estado == ST_BLOQUEADO);
`else
  // Lockout parameters have no meaning without the failure counter.
  logic w_unused;
  assign w_unused   = ^{32'(MAX_ERROS), 32'(BLOQUEIO), w_falha, w_sucesso, w_fim_bloq};
  assign tentativas = '0;
  assign bloqueado  = 1'b0;
`endif

  always_comb begin
    w_prox        = r_estado;
    w_pos_prox    = r_pos;
    w_difere_prox = r_difere;
    w_aceita      = 1'b0;
    w_tmr_en      = 1'b0;
    w_limite      = (N_TMR+1)'(TIMEOUT);
    w_sucesso     = 1'b0;
    w_falha       = 1'b0;
    w_fim_bloq    = 1'b0;
    case (r_estado)
      ST_IDLE: begin
        w_pos_prox    = '0;
        w_difere_prox = 1'b0;
        if (digito_valido) begin
          w_aceita      = 1'b1;
          w_difere_prox = (digito != w_dig_esp);
          w_pos_prox    = N_POS'(1);
          w_prox        = (DIGITOS == 1) ? ST_COMPARA : ST_RECEBE;
        end
      end
      ST_RECEBE: begin
        w_tmr_en = 1'b1;
        // A digit arriving on the terminal count still counts.
        if (digito_valido) begin
          w_aceita      = 1'b1;
          w_difere_prox = r_difere | (digito != w_dig_esp);
          w_pos_prox    = r_pos + N_POS'(1);
          if (r_pos == ULTIMA)
            w_prox = ST_COMPARA;
        end else if (w_fim) begin
          w_prox = ST_EXPIROU;
        end
      end
      ST_COMPARA: begin
        if (!r_difere) begin
          w_sucesso = 1'b1;
          w_prox    = ST_ABERTO;
        end else begin
          w_falha = 1'b1;
`ifdef UC_FECHADURA_BLOQUEIO_EN
          w_prox  = (w_tent_inc == 4'(MAX_ERROS)) ? ST_BLOQUEADO : ST_ERRO;
`else
          w_prox  = ST_ERRO;
`endif
        end
      end
      ST_ABERTO: begin
        w_tmr_en = 1'b1;
        w_limite = (N_TMR+1)'(TEMPO_ABERTO);
        if (w_fim)
          w_prox = ST_IDLE;
      end
      ST_ERRO:    w_prox = ST_IDLE;
      ST_EXPIROU: w_prox = ST_IDLE;
`ifdef UC_FECHADURA_BLOQUEIO_EN
      ST_BLOQUEADO: begin
        w_tmr_en = 1'b1;
        w_limite = (N_TMR+1)'(BLOQUEIO);
        if (w_fim) begin
          w_fim_bloq = 1'b1;
          w_prox     = ST_IDLE;
        end
      end
`endif
      default: w_prox = ST_IDLE;
    endcase
    // Position only lives while an attempt is in progress.
    if (w_prox != ST_RECEBE && w_prox != ST_COMPARA)
      w_pos_prox = '0;
  end

  assign w_tmr_clr = (w_prox != r_estado) || w_aceita;

  temporizador_uc #(.N_TMR(N_TMR)) u_tmr (
    .clock    (clock),
    .zera_n   (zera_n),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .i_limite (w_limite),
    .o_fim    (w_fim)
  );

  always_ff @(posedge clock) begin
    if (!zera_n) begin
      r_estado <= ST_IDLE;
      r_pos    <= '0;
      r_difere <= 1'b0;
    end else begin
      r_estado <= w_prox;
      r_pos    <= w_pos_prox;
      r_difere <= w_difere_prox;
    end
  end

  assign aberto  = (r_estado == ST_ABERTO);
  assign erro    = (r_estado == ST_ERRO);
  assign expirou = (r_estado == ST_EXPIROU);
  assign posicao = r_pos;
  assign estado  = r_estado;

endmodule

// File: tb/tb_uc_fechadura.sv
// Directed bench for uc_fechadura: result pulses are matched against a scoreboard of expected events.
module tb_uc_fechadura;

  localparam int K_AB = 1, K_ER = 2, K_EX = 3, K_BL = 4;

  typedef struct {
    int kind;
    int dur;
  } ev_t;

  logic        clock = 1'b0;
  logic        zera_n;
  logic        digito_valido;
  logic [3:0]  digito;
  logic [15:0] senha;
  logic        aberto, erro, expirou, bloqueado;
  logic [1:0]  posicao;
  logic [3:0]  tentativas;
  logic [3:0]  estado;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  checks = 0;
  int  errors = 0;
  int  run_ab = 0, run_er = 0, run_ex = 0, run_bl = 0;
  int  bloq_total = 0;
  int  tent_mdl = 0;

  always #5 clock = ~clock;

  uc_fechadura dut (
    .clock         (clock),
    .zera_n        (zera_n),
    .digito_valido (digito_valido),
    .digito        (digito),
    .senha         (senha),
    .aberto        (aberto),
    .erro          (erro),
    .expirou       (expirou),
    .bloqueado     (bloqueado),
    .posicao       (posicao),
    .tentativas    (tentativas),
    .estado        (estado)
  );

  // Turn each output pulse into an event with its length once it ends.
  always @(negedge clock) begin
    if (bloqueado === 1'b1) bloq_total++;
    if (aberto === 1'b1) run_ab++;
    else if (run_ab > 0) begin obs_q.push_back('{K_AB, run_ab}); run_ab = 0; end
    if (erro === 1'b1) run_er++;
    else if (run_er > 0) begin obs_q.push_back('{K_ER, run_er}); run_er = 0; end
    if (expirou === 1'b1) run_ex++;
    else if (run_ex > 0) begin obs_q.push_back('{K_EX, run_ex}); run_ex = 0; end
    if (bloqueado === 1'b1) run_bl++;
    else if (run_bl > 0) begin obs_q.push_back('{K_BL, run_bl}); run_bl = 0; end
  end

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic [3:0] d);
    digito_valido = 1'b1;
    digito        = d;
    tick();
    digito_valido = 1'b0;
  endtask

  task automatic entrada(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    strobe(a); tick();
    strobe(b); tick();
    strobe(c); tick();
    strobe(d);
  endtask

  task automatic espera(input string tag);
    int  t;
    ev_t o, e;
    t = 0;
    while (obs_q.size() == 0 && t < 200) begin
      tick();
      t++;
    end
    checks++;
    assert (obs_q.size() > 0 && exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_event observed_q=%0d expected_q=%0d", tag, obs_q.size(), exp_q.size());
    end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_kind"}, o.kind, e.kind);
      chk({tag, "_dur"}, o.dur, e.dur);
    end
  endtask

  initial begin
    zera_n        = 1'b0;
    digito_valido = 1'b0;
    digito        = 4'd0;
    senha         = 16'h4321;
    tick(); tick();
    chk("rst_estado", int'(estado), 0);
    chk("rst_posicao", int'(posicao), 0);
    chk("rst_tent", int'(tentativas), 0);
    chk("rst_saidas", int'({aberto, erro, expirou, bloqueado}), 0);
    zera_n = 1'b1;
    tick();

    // Correct password opens for TEMPO_ABERTO cycles.
    exp_q.push_back('{K_AB, 4});
    entrada(4'd1, 4'd2, 4'd3, 4'd4);
    chk("ok_compara", int'(estado), 2);
    tick();
    chk("ok_aberto_estado", int'(estado), 3);
    chk("ok_aberto", int'(aberto), 1);
    espera("ok");
    chk("ok_idle", int'(estado), 0);
    chk("ok_tent", int'(tentativas), 0);
    tick();

    // Wrong third digit.
    exp_q.push_back('{K_ER, 1});
    entrada(4'd1, 4'd2, 4'd9, 4'd4);
    tick();
    chk("err_estado", int'(estado), 4);
    chk("err_pulso", int'(erro), 1);
    espera("err");
`ifdef UC_FECHADURA_BLOQUEIO_EN
    tent_mdl++;
`endif
    chk("err_tent", int'(tentativas), tent_mdl);
    tick();

    // Timeout after TIMEOUT idle cycles in RECEBE.
    exp_q.push_back('{K_EX, 1});
    strobe(4'd1);
    chk("tmo_pos1", int'(posicao), 1);
    chk("tmo_recebe", int'(estado), 1);
    repeat (7) tick();
    chk("tmo_ainda_recebe", int'(estado), 1);
    tick();
    chk("tmo_expirou_estado", int'(estado), 5);
    chk("tmo_expirou", int'(expirou), 1);
    tick();
    chk("tmo_idle", int'(estado), 0);
    chk("tmo_pos0", int'(posicao), 0);
    espera("tmo");
    chk("tmo_tent", int'(tentativas), tent_mdl);
    tick();

`ifdef UC_FECHADURA_BLOQUEIO_EN
    // Two more failures reach MAX_ERROS.
    exp_q.push_back('{K_ER, 1});
    entrada(4'd1, 4'd2, 4'd3, 4'd5);
    espera("err2");
    tent_mdl++;
    chk("err2_tent", int'(tentativas), tent_mdl);
    tick();
    exp_q.push_back('{K_BL, 6});
    entrada(4'd7, 4'd7, 4'd7, 4'd7);
    chk("blq_compara", int'(estado), 2);
    tick();
    chk("blq_estado", int'(estado), 6);
    chk("blq_saida", int'(bloqueado), 1);
    chk("blq_tent_max", int'(tentativas), 3);
    strobe(4'd1); strobe(4'd2); strobe(4'd3); strobe(4'd4);
    chk("blq_ignora_estado", int'(estado), 6);
    chk("blq_ignora_pos", int'(posicao), 0);
    espera("blq");
    tent_mdl = 0;
    chk("blq_tent_fim", int'(tentativas), 0);
    chk("blq_idle", int'(estado), 0);
    chk("blq_total", bloq_total, 6);
    tick();
`else
    // Without lockout every failure is a plain error pulse.
    for (int n = 0; n < 4; n++) begin
      exp_q.push_back('{K_ER, 1});
      entrada(4'd7, 4'd7, 4'd7, 4'd7);
      espera("err_sem_blq");
      tick();
    end
    chk("sem_blq_tent", int'(tentativas), 0);
    chk("sem_blq_total", bloq_total, 0);
`endif

    // Reset in the middle of an attempt.
    strobe(4'd1); tick();
    strobe(4'd2);
    chk("rmid_pos", int'(posicao), 2);
    zera_n = 1'b0;
    tick();
    zera_n = 1'b1;
    chk("rmid_estado", int'(estado), 0);
    chk("rmid_pos0", int'(posicao), 0);
    tick();
    exp_q.push_back('{K_AB, 4});
    entrada(4'd1, 4'd2, 4'd3, 4'd4);
    espera("rmid_ok");
    chk("rmid_tent", int'(tentativas), 0);
    tick(); tick();

    chk("fila_obs", obs_q.size(), 0);
    chk("fila_exp", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
